// File: rtl/game_ctl.sv
`default_nettype none
// ============================================================================
// Module   : game_ctl
// Purpose  : VGA game sequencer. Runs the IDLE/WAIT/GAME/SCORE state machine,
//            publishes the clickable play-rectangle geometry, and keeps a
//            frame-based game timer plus a saturating hit counter.
// Revision : 1.0 - initial release
// ============================================================================
module game_ctl #(
  parameter int FRAMES_PER_SEC   = 60,
  parameter int GAME_SECONDS     = 30,
  parameter int WAIT_TIMEOUT_SEC = 10,
  parameter int SCORE_HOLD_SEC   = 5,
  parameter int PLAY_HSTART      = 380,
  parameter int PLAY_VSTART      = 186,
  parameter int PLAY_HLENGTH     = 300,
  parameter int PLAY_VLENGTH     = 100
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        play_clicked,
  input  logic        stop_clicked,
  input  logic        remote_start,
  input  logic        hit,
  output logic [1:0]  state,
  output logic [10:0] rect_hstart,
  output logic [10:0] rect_vstart,
  output logic [10:0] rect_hlength,
  output logic [10:0] rect_vlength,
  output logic [7:0]  time_left,
  output logic [7:0]  score,
  output logic        game_start,
  output logic        game_over
);

  localparam int c_FC_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;

  // Geometry of the play rectangle; all-zero disables clicking in click_ctl.
  localparam logic [43:0] c_RECT_PLAY = {11'(PLAY_HSTART), 11'(PLAY_VSTART),
                                         11'(PLAY_HLENGTH), 11'(PLAY_VLENGTH)};
  localparam logic [43:0] c_RECT_OFF  = 44'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GAME  = 2'd2,
    ST_SCORE = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_vblnk_d;
  logic [c_FC_W-1:0] r_frame_cnt;
  logic [7:0]        r_sec_cnt;

  logic       w_frame_tick;
  logic       w_sec_tick;
  logic       w_wait_timeout;
  logic       w_score_timeout;
  logic       w_game_expire;
  logic       w_leave;
  logic [7:0] w_score_inc;

  assign state = r_state;

  assign w_frame_tick    = vblnk & ~r_vblnk_d;
  assign w_sec_tick      = w_frame_tick && (r_frame_cnt == c_FC_W'(FRAMES_PER_SEC - 1));
  // Timeouts fire on the tick that would complete the Nth second.
  assign w_wait_timeout  = w_sec_tick && (r_sec_cnt == 8'(WAIT_TIMEOUT_SEC - 1));
  assign w_score_timeout = w_sec_tick && (r_sec_cnt == 8'(SCORE_HOLD_SEC - 1));
  assign w_game_expire   = w_sec_tick && (time_left == 8'd1);
  assign w_score_inc     = (score == 8'hFF) ? score : score + 8'd1;

  // Any state transition this cycle; used to restart the per-state timing.
  assign w_leave = ((r_state == ST_IDLE)  && play_clicked) ||
                   ((r_state == ST_WAIT)  && (remote_start || w_wait_timeout)) ||
                   ((r_state == ST_GAME)  && (stop_clicked || w_game_expire)) ||
                   ((r_state == ST_SCORE) && (play_clicked || w_score_timeout));

  // Frame/second timebase, restarted from zero whenever the state changes.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vblnk_d   <= 1'b0;
      r_frame_cnt <= '0;
      r_sec_cnt   <= 8'd0;
    end else begin
      r_vblnk_d <= vblnk;
      if (w_leave) begin
        r_frame_cnt <= '0;
        r_sec_cnt   <= 8'd0;
      end else if (w_frame_tick) begin
        if (w_sec_tick) begin
          r_frame_cnt <= '0;
          r_sec_cnt   <= r_sec_cnt + 8'd1;
        end else begin
          r_frame_cnt <= r_frame_cnt + c_FC_W'(1);
        end
      end
    end
  end

  // Game state machine with registered geometry, timer, score and pulses.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      {rect_hstart, rect_vstart, rect_hlength, rect_vlength} <= c_RECT_PLAY;
      time_left  <= 8'd0;
      score      <= 8'd0;
      game_start <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      game_start <= 1'b0;
      game_over  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (play_clicked) begin
            r_state <= ST_WAIT;
            {rect_hstart, rect_vstart, rect_hlength, rect_vlength} <= c_RECT_OFF;
          end
        end
        ST_WAIT: begin
          // Opponent readiness beats a coincident timeout.
          if (remote_start) begin
            r_state    <= ST_GAME;
            time_left  <= 8'(GAME_SECONDS);
            score      <= 8'd0;
            game_start <= 1'b1;
          end else if (w_wait_timeout) begin
            r_state <= ST_IDLE;
            {rect_hstart, rect_vstart, rect_hlength, rect_vlength} <= c_RECT_PLAY;
          end
        end
        ST_GAME: begin
          // A hit is counted even in the cycle the game ends.
          if (hit) begin
            score <= w_score_inc;
          end
          if (stop_clicked) begin
            r_state <= ST_IDLE;
            {rect_hstart, rect_vstart, rect_hlength, rect_vlength} <= c_RECT_PLAY;
          end else if (w_sec_tick) begin
            time_left <= time_left - 8'd1;
            if (w_game_expire) begin
              r_state   <= ST_SCORE;
              game_over <= 1'b1;
              {rect_hstart, rect_vstart, rect_hlength, rect_vlength} <= c_RECT_PLAY;
            end
          end
        end
        ST_SCORE: begin
          if (play_clicked || w_score_timeout) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/game_ctl.md
Name: game_ctl

Overview:
- Top-level game sequencer for the VGA game: owns the IDLE/WAIT/GAME/SCORE state machine.
- Drives the geometry of the clickable "play" rectangle, shared by the click controller and the rect/char overlay.
- Runs a frame-based game timer and a hit/score counter.
- Outputs the current state, so the top level can select which overlay's RGB reaches sync_delay.
- Sits in the pclk domain between cursor_sync/click_ctl and the overlay multiplexer.

Parameters:
FRAMES_PER_SEC, 60, vblnk rising edges per timer second
GAME_SECONDS, 30, game duration in seconds (1..255)
WAIT_TIMEOUT_SEC, 10, seconds in WAIT before returning to IDLE
SCORE_HOLD_SEC, 5, seconds SCORE is shown before returning to IDLE
PLAY_HSTART, 380, play rectangle x start
PLAY_VSTART, 186, play rectangle y start
PLAY_HLENGTH, 300, play rectangle width
PLAY_VLENGTH, 100, play rectangle height

Ports:
pclk  in  1  pixel clock (40 MHz); the only clock
rst  in  1  synchronous, active-high reset
vblnk  in  1  vertical blank from the timing chain; each rising edge is one frame tick
play_clicked  in  1  single-cycle pulse from click_ctl, play rectangle clicked
stop_clicked  in  1  single-cycle pulse, stop requested during the game
remote_start  in  1  level from the UART side, opponent ready
hit  in  1  single-cycle pulse, player scored
state  out  2  0=IDLE 1=WAIT 2=GAME 3=SCORE
rect_hstart  out  11  play rectangle x start
rect_vstart  out  11  play rectangle y start
rect_hlength  out  11  play rectangle width
rect_vlength  out  11  play rectangle height
time_left  out  8  remaining game seconds
score  out  8  hit count
game_start  out  1  one-cycle pulse on entry to GAME
game_over  out  1  one-cycle pulse on entry to SCORE

Behaviour:
- All outputs are registered. A response appears on the pclk edge after the causing input is sampled (1-cycle latency).
- Reset values:
  - state=IDLE.
  - rect_* = PLAY_* parameters.
  - time_left=0, score=0.
  - game_start=0, game_over=0.
  - Internal vblnk delay register=0, frame counter=0, second counter=0.
- Frame tick = vblnk & ~vblnk_d.
- Frame counter: 0..FRAMES_PER_SEC-1, increments on each frame tick. sec_tick is asserted on the tick where the counter wraps to 0.
- Frame and second counters clear on every state transition, so each state's timing starts from 0.
- Rectangle config:
  - In IDLE and SCORE, rect_* = PLAY_*.
  - In WAIT and GAME, rect_* = 0. Zero length means click_ctl can never report a click.
- IDLE:
  - play_clicked -> WAIT.
  - All other inputs ignored.
- WAIT:
  - remote_start=1 -> GAME; load time_left=GAME_SECONDS, clear score, pulse game_start.
  - Else, second counter reaching WAIT_TIMEOUT_SEC -> IDLE.
  - If remote_start and the timeout occur in the same cycle, remote_start wins.
- GAME:
  - Each sec_tick decrements time_left.
  - On a sec_tick with time_left==1: time_left becomes 0 -> SCORE, pulse game_over.
  - stop_clicked -> IDLE; score and time_left hold their values. stop_clicked has priority over expiry in the same cycle.
  - hit increments score, saturating at 255. A hit in the expiry cycle or the stop cycle is still counted.
- SCORE:
  - score and time_left hold.
  - play_clicked or second counter reaching SCORE_HOLD_SEC -> IDLE.
  - hit is ignored.
- hit is ignored outside GAME.
- stop_clicked is ignored outside GAME.
- Reset asserted mid-game returns to the reset values on the next edge, regardless of state; no pulse is emitted.
- State encoding is exactly as listed; state value 3 is SCORE (no illegal codes exist).

Test Plan:
- Reset, then 3 frames idle -> state=0, rect_*=380/186/300/100, time_left=0, score=0, no pulses.
- play_clicked pulse -> next cycle state=1, rect_*=0. Raise remote_start -> next cycle state=2, time_left=30, score=0, game_start high for exactly one cycle.
- In GAME with FRAMES_PER_SEC=2, GAME_SECONDS=3:
  - 3 hit pulses, then 6 vblnk edges -> time_left steps 3,2,1,0.
  - state=3 on the expiry edge, game_over single pulse, score=3.
  - SCORE_HOLD_SEC=5 elapses -> state=0.
- WAIT with remote_start=0 for WAIT_TIMEOUT_SEC*FRAMES_PER_SEC frames -> state returns to 0.
- Same test with remote_start asserted on the timeout cycle -> state=2.
- In GAME, stop_clicked on the same cycle as the final sec_tick plus a hit:
  - state=0, game_over stays 0, score incremented by 1.
  - Separately: 300 hits -> score saturates at 255.
- rst pulsed while in GAME with time_left=17, score=9 -> next edge state=0, time_left=0, score=0, rect_*=PLAY_*.
